bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/fe_pkg.sv | 18 +
 rtl/bus_arbiter.sv | 120 ++++++++++++
 tb/tb_bus_arbiter.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fe_pkg.sv
// Front-end shared types: bus arbiter states, master index, RV32I operand.
// Imported by the bus arbiter and its bench.
package fe_pkg;

  typedef logic [31:0] RV32I_OPERAND_t;

  typedef logic master_idx_t;

  localparam master_idx_t MASTER_CORE = 1'b0;
  localparam master_idx_t MASTER_DBG  = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    ACK
  } arb_state_t;

endpackage

// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter onto a single memory-controller bus.
// One transaction in flight: IDLE -> ISSUE (1+WAIT_STATES) -> ACK.
module bus_arbiter
  import fe_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           m0_req,
  input  RV32I_OPERAND_t m0_addr,
  input  RV32I_OPERAND_t m0_wrdata,
  input  logic           m0_wren,
  output logic           m0_ack,
  input  logic           m1_req,
  input  RV32I_OPERAND_t m1_addr,
  input  RV32I_OPERAND_t m1_wrdata,
  input  logic           m1_wren,
  output logic           m1_ack,
  output RV32I_OPERAND_t rddata,
  output RV32I_OPERAND_t bus_addr,
  output RV32I_OPERAND_t bus_wrdata,
  output logic           bus_wren,
  input  RV32I_OPERAND_t bus_rddata,
  output logic           owner,
  output logic           busy
);

  localparam logic [3:0] WAIT_LD = 4'(WAIT_STATES);

  arb_state_t     state_q;
  arb_state_t     state_d;
  master_idx_t    owner_q;
  master_idx_t    last_q;
  master_idx_t    winner;
  RV32I_OPERAND_t addr_q;
  RV32I_OPERAND_t wrdata_q;
  RV32I_OPERAND_t rddata_q;
  logic           wren_q;
  logic [3:0]     wait_q;
  logic           any_req;
  logic           issue_done;
  logic           in_issue;

  assign any_req    = m0_req | m1_req;
  assign issue_done = (wait_q == 4'd0);
  assign in_issue   = (state_q == ISSUE);

  // Under contention the master that did not win last time goes first.
  always_comb begin
    winner = MASTER_CORE;
    if (m0_req && m1_req)
      winner = ~last_q;
    else if (m1_req)
      winner = MASTER_DBG;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_req) state_d = ISSUE;
      ISSUE:   if (issue_done) state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q  <= MASTER_CORE;
      last_q   <= MASTER_DBG;
      addr_q   <= '0;
      wrdata_q <= '0;
      wren_q   <= 1'b0;
      rddata_q <= '0;
      wait_q   <= 4'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (any_req) begin
            owner_q  <= winner;
            addr_q   <= winner ? m1_addr : m0_addr;
            wrdata_q <= winner ? m1_wrdata : m0_wrdata;
            wren_q   <= winner ? m1_wren : m0_wren;
            wait_q   <= WAIT_LD;
          end
        end
        ISSUE: begin
          if (issue_done) begin
            if (!wren_q)
              rddata_q <= bus_rddata;
          end else begin
            wait_q <= wait_q - 4'd1;
          end
        end
        ACK:     last_q <= owner_q;
        default: ;
      endcase
    end
  end

  // Bus is gated by state so an async reset clears it at once.
  assign bus_addr   = in_issue ? addr_q : '0;
  assign bus_wrdata = in_issue ? wrdata_q : '0;
  assign bus_wren   = in_issue & wren_q;

  assign m0_ack = (state_q == ACK) && (owner_q == MASTER_CORE);
  assign m1_ack = (state_q == ACK) && (owner_q == MASTER_DBG);
  assign rddata = rddata_q;
  assign owner  = owner_q;
  assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: transaction-level model plus cycle monitor.
// Directed scenarios followed by randomized two-master traffic.
module tb_bus_arbiter;
  import fe_pkg::*;

  localparam int W = 2;

  typedef struct packed {
    logic        master;
    logic [31:0] addr;
    logic [31:0] wrdata;
    logic        wren;
    int          gcyc;
  } txn_t;

  logic           clk;
  logic           rst;
  logic [1:0]     dreq;
  RV32I_OPERAND_t daddr [2];
  RV32I_OPERAND_t dwd [2];
  logic [1:0]     dwr;
  logic           m0_ack;
  logic           m1_ack;
  RV32I_OPERAND_t rddata;
  RV32I_OPERAND_t bus_addr;
  RV32I_OPERAND_t bus_wrdata;
  logic           bus_wren;
  RV32I_OPERAND_t bus_rddata;
  logic           owner;
  logic           busy;

  txn_t        q[$];
  int          head = 0;
  int          cyc = 0;
  int          free_at = 0;
  logic        last_m = 1'b1;
  logic [31:0] model_rd = '0;
  int          vectors = 0;
  int          miscompares = 0;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    if (a == 32'h10)
      return 32'hCAFE0001;
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  assign bus_rddata = mem_f(bus_addr);

  bus_arbiter #(.WAIT_STATES(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .m0_req     (dreq[0]),
    .m0_addr    (daddr[0]),
    .m0_wrdata  (dwd[0]),
    .m0_wren    (dwr[0]),
    .m0_ack     (m0_ack),
    .m1_req     (dreq[1]),
    .m1_addr    (daddr[1]),
    .m1_wrdata  (dwd[1]),
    .m1_wren    (dwr[1]),
    .m1_ack     (m1_ack),
    .rddata     (rddata),
    .bus_addr   (bus_addr),
    .bus_wrdata (bus_wrdata),
    .bus_wren   (bus_wren),
    .bus_rddata (bus_rddata),
    .owner      (owner),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: grants at free sampling edges, round robin.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      last_m  = 1'b1;
      free_at = 0;
    end else begin
      txn_t t;
      logic win;
      cyc = cyc + 1;
      if (cyc >= free_at && (dreq[0] || dreq[1])) begin
        win      = (dreq[0] && dreq[1]) ? ~last_m : dreq[1];
        t.master = win;
        t.addr   = daddr[win];
        t.wrdata = dwd[win];
        t.wren   = dwr[win];
        t.gcyc   = cyc;
        q.push_back(t);
        last_m   = win;
        free_at  = cyc + W + 3;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors = vectors + 1;
    if (act !== exp) begin
      miscompares = miscompares + 1;
      $display("FAIL %s: got %h expected %h at cyc %0d",
               nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    txn_t        h;
    logic        hv;
    logic        iss;
    logic        ackc;
    logic [31:0] exp;
    if (rst) begin
      head     = q.size();
      model_rd = '0;
      chk("rst_bus_addr", bus_addr, 32'h0);
      chk("rst_bus_wrdata", bus_wrdata, 32'h0);
      chk("rst_bus_wren", 32'(bus_wren), 32'h0);
      chk("rst_acks", {30'h0, m1_ack, m0_ack}, 32'h0);
      chk("rst_rddata", rddata, 32'h0);
      chk("rst_owner", 32'(owner), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
    end else begin
      if (head < q.size() && cyc > q[head].gcyc + W + 1) begin
        chk("ack_missing", 32'(m0_ack | m1_ack), 32'h1);
        head = head + 1;
      end
      hv   = head < q.size();
      h    = hv ? q[head] : '0;
      iss  = hv && cyc >= h.gcyc && cyc <= h.gcyc + W;
      ackc = hv && cyc == h.gcyc + W + 1;
      chk("bus_addr", bus_addr, iss ? h.addr : 32'h0);
      chk("bus_wrdata", bus_wrdata, iss ? h.wrdata : 32'h0);
      chk("bus_wren", 32'(bus_wren), 32'(iss && h.wren));
      chk("busy", 32'(busy), 32'(iss || ackc));
      if (iss || ackc)
        chk("owner", 32'(owner), 32'(h.master));
      chk("two_acks", 32'(m0_ack & m1_ack), 32'h0);
      if (m0_ack || m1_ack) begin
        if (!hv) begin
          chk("ack_unexpected", 32'(m0_ack | m1_ack), 32'h0);
        end else begin
          chk("ack_master", 32'(m1_ack), 32'(h.master));
          chk("ack_cycle", 32'(cyc), 32'(h.gcyc + W + 1));
          exp = h.wren ? model_rd : mem_f(h.addr);
          chk("ack_rddata", rddata, exp);
          model_rd = exp;
          head = head + 1;
        end
      end else begin
        chk("rddata_hold", rddata, model_rd);
      end
    end
  end

  task automatic set_txn(input int i, input logic [31:0] a,
                         input logic [31:0] d, input logic w);
    daddr[i] = a;
    dwd[i]   = d;
    dwr[i]   = w;
  endtask

  function automatic logic acked(input int i);
    return (i == 0) ? m0_ack : m1_ack;
  endfunction

  function automatic logic granted(input int i);
    return head < q.size() && q[head].master == 1'(i);
  endfunction

  task automatic wait_ack(input int i);
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (acked(i)) return;
    end
    $display("FAIL wait_ack m%0d: no ack within 60 cycles", i);
    $fatal(1, "timeout");
  endtask

  task automatic wait_grant(input int i);
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (granted(i) && busy) return;
    end
    $display("FAIL wait_grant m%0d: no grant within 60 cycles", i);
    $fatal(1, "timeout");
  endtask

  task automatic drain();
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (head >= q.size() && !busy) return;
    end
    $display("FAIL drain: bus still busy after 60 cycles");
    $fatal(1, "timeout");
  endtask

  task automatic rand_txn(input int i);
    set_txn(i, $urandom & 32'hFFFF_FFFC, $urandom, 1'($urandom % 2));
  endtask

  task automatic drive_random();
    for (int i = 0; i < 2; i++) begin
      if (acked(i)) begin
        if ($urandom % 3 != 0) rand_txn(i);
        else dreq[i] = 1'b0;
      end else if (!dreq[i]) begin
        if ($urandom % 4 == 0) begin
          rand_txn(i);
          dreq[i] = 1'b1;
        end
      end else begin
        if (granted(i) && $urandom % 2 == 0) rand_txn(i);
        if ($urandom % 20 == 0) dreq[i] = 1'b0;
      end
    end
  endtask

  initial begin
    int acks;
    rst  = 1'b1;
    dreq = 2'b00;
    dwr  = 2'b00;
    for (int i = 0; i < 2; i++) begin
      daddr[i] = '0;
      dwd[i]   = '0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;

    set_txn(0, 32'h100, 32'h0, 1'b0);
    set_txn(1, 32'h200, 32'h0, 1'b0);
    dreq = 2'b11;
    acks = 0;
    for (int n = 0; n < 100 && acks < 4; n++) begin
      @(negedge clk);
      if (m0_ack || m1_ack) acks++;
    end
    if (acks < 4) begin
      $display("FAIL contention: only %0d of 4 acks", acks);
      $fatal(1, "timeout");
    end
    dreq = 2'b00;
    drain();

    set_txn(0, 32'h10, 32'h0, 1'b0);
    dreq[0] = 1'b1;
    wait_ack(0);
    dreq[0] = 1'b0;

    set_txn(1, 32'h20, 32'h55, 1'b1);
    dreq[1] = 1'b1;
    wait_ack(1);
    dreq[1] = 1'b0;

    set_txn(0, 32'h44, 32'h0, 1'b0);
    dreq[0] = 1'b1;
    wait_grant(0);
    @(negedge clk);
    dreq[0] = 1'b0;
    wait_ack(0);
    repeat (3) @(negedge clk);
    set_txn(0, 32'h48, 32'h0, 1'b0);
    dreq[0] = 1'b1;
    wait_ack(0);
    dreq[0] = 1'b0;

    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      drive_random();
    end
    dreq = 2'b00;
    drain();

    set_txn(1, 32'h80, 32'hDEAD, 1'b1);
    dreq[1] = 1'b1;
    wait_grant(1);
    @(posedge clk);
    #2 rst = 1'b1;
    dreq = 2'b00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    set_txn(0, 32'h30, 32'h0, 1'b0);
    set_txn(1, 32'h34, 32'h0, 1'b0);
    dreq = 2'b11;
    wait_ack(0);
    dreq[0] = 1'b0;
    wait_ack(1);
    dreq = 2'b00;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
